fine_time_pulse_gen: RTL and testbench

- Programmable test-pulse generator: the transmit-side counterpart of the 32-slice fine-time hit decoder.
- Each 50 MHz clock period is split into 32 slices. The block emits a 32-bit slice pattern per clock, bit k = slice k, bit 0 earliest. A downstream serializer drives this onto a detector-input line, so the injected leading edges land at programmed fine-time positions.
- Configured over the standard local bus. Used for TDC calibration and for checking the PID windows.

---
 rtl/fine_time_pulse_gen.sv | 201 ++++++++++++++++++++
 tb/tb_fine_time_pulse_gen.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fine_time_pulse_gen.sv
// fine_time_pulse_gen
// Programmable test-pulse generator. Every 50 MHz clock period is treated as
// 32 fine-time slices and the block emits one 32-bit slice pattern per clock
// (bit 0 = earliest slice). A serializer downstream turns the pattern into a
// detector-input waveform, so leading edges land at programmed fine times.
//
// Ports:
//   clk      system clock, all logic on its rising edge
//   rst      synchronous reset, active-low
//   Pattern  registered slice pattern for the current clock period
//   Busy     high while a burst / continuous run (or its tail word) is active
//   Done     one-clock strobe when a finite burst or a stop completes
//   DataOut  local-bus read data, zero unless a read hits this block
//   DataIn   local-bus write data
//   Address  local-bus address
//   Read     local-bus read strobe
//   Write    local-bus write strobe
//
// Register map (Base+n):
//   0 CTRL   [0] START, [1] STOP (both self-clearing), [31:16] BURST
//   1 SHAPE  [4:0] POS, [10:5] WIDTH
//   2 PERIOD [15:0] fire-to-fire spacing in clocks
//   3 STATUS [15:0] pulse count, [16] Busy (read-only)
`timescale 1ns/1ps

module fine_time_pulse_gen #(
    parameter logic [7:0]  Base      = 8'h00,
    parameter logic [15:0] DefPeriod = 16'd100
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] Pattern,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] DataOut,
    input  logic [31:0] DataIn,
    input  logic [7:0]  Address,
    input  logic        Read,
    input  logic        Write
);

    typedef enum logic [1:0] {IDLE, FIRE, TAIL, WAIT} state_t;

    state_t      state;
    logic [15:0] burst;
    logic [10:0] shape;
    logic [15:0] period;
    logic [15:0] pulse_count;
    logic [15:0] burst_shadow;
    logic [15:0] counter;
    logic [31:0] tail_word;
    logic        stop_req;

    logic        hit_ctrl;
    logic        hit_shape;
    logic        hit_period;
    logic        hit_status;
    logic        start_wr;
    logic        stop_wr;

    logic [5:0]  width_eff;
    logic [6:0]  reach;
    logic        has_tail;
    logic [63:0] span;
    logic [15:0] period_eff;
    logic        burst_done;

    assign hit_ctrl   = (Address == Base);
    assign hit_shape  = (Address == Base + 8'd1);
    assign hit_period = (Address == Base + 8'd2);
    assign hit_status = (Address == Base + 8'd3);

    assign start_wr = Write && hit_ctrl && DataIn[0];
    assign stop_wr  = Write && hit_ctrl && DataIn[1];

    // Pulse geometry from the live SHAPE/PERIOD registers; the FIRE state
    // samples these, which is what makes the settings take effect per fire.
    // The 64-bit span holds the first word in [31:0] and the spill in [63:32].
    always_comb begin
        if (shape[10:5] == 6'd0) begin
            width_eff = 6'd1;
        end else if (shape[10:5] > 6'd32) begin
            width_eff = 6'd32;
        end else begin
            width_eff = shape[10:5];
        end
        reach      = {2'b00, shape[4:0]} + {1'b0, width_eff};
        has_tail   = (reach > 7'd32);
        span       = ((64'd1 << width_eff) - 64'd1) << shape[4:0];
        period_eff = (period < 16'd2) ? 16'd2 : period;
    end

    assign burst_done = (burst_shadow != 16'd0) && (pulse_count == burst_shadow);

    // Local-bus register bank. STATUS is read-only, writes to it are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            burst  <= 16'd0;
            shape  <= 11'd0;
            period <= DefPeriod;
        end else if (Write) begin
            if (hit_ctrl) begin
                burst <= DataIn[31:16];
            end
            if (hit_shape) begin
                shape <= DataIn[10:0];
            end
            if (hit_period) begin
                period <= DataIn[15:0];
            end
        end
    end

    // Pulse sequencer. The counter is loaded with PERIOD-1 at each fire and
    // a continuing run re-enters FIRE when it reaches 1, so first words are
    // exactly PERIOD clocks apart. A finishing burst instead lets the counter
    // reach 0 so Done lands on the clock where the next fire would have been.
    // STOP is only acted on in WAIT, so a pending tail word is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            Pattern      <= 32'd0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            pulse_count  <= 16'd0;
            burst_shadow <= 16'd0;
            counter      <= 16'd0;
            tail_word    <= 32'd0;
            stop_req     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    Pattern  <= 32'd0;
                    stop_req <= 1'b0;
                    if (start_wr) begin
                        state        <= FIRE;
                        Busy         <= 1'b1;
                        pulse_count  <= 16'd0;
                        burst_shadow <= DataIn[31:16];
                        stop_req     <= stop_wr;
                    end
                end
                FIRE: begin
                    Pattern      <= span[31:0];
                    tail_word    <= span[63:32];
                    counter      <= period_eff - 16'd1;
                    burst_shadow <= burst;
                    stop_req     <= stop_req | stop_wr;
                    if (pulse_count != 16'hFFFF) begin
                        pulse_count <= pulse_count + 16'd1;
                    end
                    state <= has_tail ? TAIL : WAIT;
                end
                TAIL: begin
                    Pattern  <= tail_word;
                    counter  <= counter - 16'd1;
                    stop_req <= stop_req | stop_wr;
                    state    <= WAIT;
                end
                WAIT: begin
                    Pattern  <= 32'd0;
                    stop_req <= stop_req | stop_wr;
                    if (stop_req || (burst_done && counter == 16'd0)) begin
                        state    <= IDLE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        stop_req <= 1'b0;
                    end else begin
                        if (counter != 16'd0) begin
                            counter <= counter - 16'd1;
                        end
                        if (!burst_done && counter <= 16'd1) begin
                            state <= FIRE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // OR-bus read mux: drives zero unless this block is addressed.
    always_comb begin
        DataOut = 32'd0;
        if (Read) begin
            if (hit_ctrl) begin
                DataOut = {burst, 16'd0};
            end else if (hit_shape) begin
                DataOut = {21'd0, shape};
            end else if (hit_period) begin
                DataOut = {16'd0, period};
            end else if (hit_status) begin
                DataOut = {15'd0, Busy, pulse_count};
            end
        end
    end

endmodule

// File: tb/tb_fine_time_pulse_gen.sv
// tb_fine_time_pulse_gen
// Self-checking bench for fine_time_pulse_gen. A schedule-based reference
// model (absolute cycle numbers for the next fire, tail word and end of run,
// pulse shapes built slice by slice) predicts Pattern/Busy/Done every clock
// and the read data of every bus read. Directed scenarios come first, then
// a randomized stretch of bus writes, reads and occasional resets.
`timescale 1ns/1ps

module tb_fine_time_pulse_gen;

    localparam logic [7:0]  BASE       = 8'h20;
    localparam logic [15:0] DEF_PERIOD = 16'd100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Pattern;
    logic        Busy;
    logic        Done;
    logic [31:0] DataOut;
    logic [31:0] DataIn;
    logic [7:0]  Address;
    logic        Read;
    logic        Write;

    int assertions = 0;
    int failures   = 0;

    // Reference model state
    logic [15:0] m_burst;
    logic [10:0] m_shape;
    logic [15:0] m_period;
    logic [15:0] m_count;
    logic [15:0] m_burst_sh;
    logic        m_run;
    logic        m_stop;
    logic [31:0] m_tail_word;
    int          cyc = 0;
    int          m_next_fire = -1;
    int          m_tail_at = -1;
    int          m_end_at = -1;
    logic [31:0] exp_pat;
    logic        exp_done;

    fine_time_pulse_gen #(.Base(BASE), .DefPeriod(DEF_PERIOD)) dut (
        .clk     (clk),
        .rst     (rst),
        .Pattern (Pattern),
        .Busy    (Busy),
        .Done    (Done),
        .DataOut (DataOut),
        .DataIn  (DataIn),
        .Address (Address),
        .Read    (Read),
        .Write   (Write)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        assertions++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [7:0] a);
        if (a == BASE)              return {m_burst, 16'd0};
        else if (a == BASE + 8'd1)  return {21'd0, m_shape};
        else if (a == BASE + 8'd2)  return {16'd0, m_period};
        else if (a == BASE + 8'd3)  return {15'd0, m_run, m_count};
        else                        return 32'd0;
    endfunction

    // Advances the model by one clock edge using the inputs present at it.
    task automatic modelStep(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
        logic        prev_run, start, stopw;
        int          pos, width, peff, spacing;
        logic [31:0] first, tail;
        cyc++;
        exp_pat  = 32'd0;
        exp_done = 1'b0;
        if (!r) begin
            m_burst = 16'd0; m_shape = 11'd0; m_period = DEF_PERIOD;
            m_count = 16'd0; m_burst_sh = 16'd0; m_run = 1'b0; m_stop = 1'b0;
            m_next_fire = -1; m_tail_at = -1; m_end_at = -1;
        end else begin
            prev_run = m_run;
            start = w && (a == BASE) && d[0];
            stopw = w && (a == BASE) && d[1];
            if (m_run) begin
                if (cyc == m_next_fire) begin
                    pos   = int'(m_shape[4:0]);
                    width = int'(m_shape[10:5]);
                    if (width == 0) width = 1;
                    else if (width > 32) width = 32;
                    first = 32'd0;
                    tail  = 32'd0;
                    for (int s = pos; s < pos + width; s++) begin
                        if (s < 32) first[s] = 1'b1;
                        else        tail[s - 32] = 1'b1;
                    end
                    exp_pat = first;
                    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                    m_burst_sh = m_burst;
                    peff = (m_period < 16'd2) ? 2 : int'(m_period);
                    m_tail_word = tail;
                    m_tail_at = (tail != 32'd0) ? cyc + 1 : -1;
                    spacing = peff;
                    if (tail != 32'd0 && spacing < 3) spacing = 3;
                    if (m_burst_sh != 16'd0 && m_count == m_burst_sh) begin
                        m_end_at = cyc + peff;
                        m_next_fire = -1;
                    end else begin
                        m_next_fire = cyc + spacing;
                    end
                end else if (cyc == m_tail_at) begin
                    exp_pat = m_tail_word;
                end else if (cyc == m_end_at || m_stop) begin
                    m_run = 1'b0;
                    exp_done = 1'b1;
                    m_next_fire = -1;
                    m_end_at = -1;
                end
            end
            if (start && !prev_run) begin
                m_run = 1'b1;
                m_next_fire = cyc + 1;
                m_tail_at = -1;
                m_end_at = -1;
                m_count = 16'd0;
                m_stop = stopw;
                m_burst_sh = d[31:16];
            end else begin
                m_stop = m_run && (m_stop || stopw);
            end
            if (w) begin
                if (a == BASE)              m_burst = d[31:16];
                else if (a == BASE + 8'd1)  m_shape = d[10:0];
                else if (a == BASE + 8'd2)  m_period = d[15:0];
            end
        end
    endtask

    // Drives one clock's worth of inputs, steps the model and checks outputs.
    task automatic applyStimulus(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
        rst     = r;
        Write   = w;
        Address = a;
        DataIn  = d;
        Read    = 1'b0;
        @(posedge clk);
        modelStep(r, w, a, d);
        #1;
        Write = 1'b0;
        checkOutput("pattern", Pattern, exp_pat);
        checkOutput("busy", {31'd0, Busy}, {31'd0, m_run});
        checkOutput("done", {31'd0, Done}, {31'd0, exp_done});
    endtask

    task automatic writeReg(input logic [7:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, a, d);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
    endtask

    task automatic readCheck(input string tag, input logic [7:0] a);
        Address = a;
        Read    = 1'b1;
        #1;
        checkOutput(tag, DataOut, modelRead(a));
        Read = 1'b0;
        #1;
        checkOutput("read_idle", DataOut, 32'd0);
    endtask

    task automatic readExpect(input string tag, input logic [7:0] a, input logic [31:0] want);
        Address = a;
        Read    = 1'b1;
        #1;
        checkOutput(tag, DataOut, want);
        Read = 1'b0;
    endtask

    initial begin
        int          r;
        logic [7:0]  a;
        logic [31:0] d;
        rst = 1'b0; Write = 1'b0; Read = 1'b0; Address = 8'h00; DataIn = 32'd0;

        // Reset state
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 32'd0);
        readExpect("rst_period", BASE + 8'd2, 32'd100);
        readExpect("rst_ctrl", BASE, 32'd0);
        readExpect("rst_status", BASE + 8'd3, 32'd0);
        idleCycles(2);

        // Single in-word pulse, POS=5 WIDTH=4
        writeReg(BASE + 8'd1, 32'h0000_0085);
        writeReg(BASE + 8'd2, 32'd8);
        writeReg(BASE, {16'd1, 16'h0001});
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
        checkOutput("t1_word", Pattern, 32'h0000_01E0);
        idleCycles(9);
        readExpect("t1_status", BASE + 8'd3, 32'h0000_0001);

        // Spill into next word, POS=30 WIDTH=4
        writeReg(BASE + 8'd1, 32'h0000_009E);
        writeReg(BASE, {16'd1, 16'h0001});
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
        checkOutput("t2_first", Pattern, 32'hC000_0000);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
        checkOutput("t2_tail", Pattern, 32'h0000_0003);
        idleCycles(10);

        // Extremes
        writeReg(BASE + 8'd1, 32'h0000_0400);
        writeReg(BASE, {16'd1, 16'h0001});
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
        checkOutput("t3_full", Pattern, 32'hFFFF_FFFF);
        idleCycles(10);
        writeReg(BASE + 8'd1, 32'h0000_001F);
        writeReg(BASE, {16'd1, 16'h0001});
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
        checkOutput("t3_w0", Pattern, 32'h8000_0000);
        idleCycles(10);
        writeReg(BASE + 8'd1, 32'h0000_041F);
        writeReg(BASE, {16'd1, 16'h0001});
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
        checkOutput("t3_p31_first", Pattern, 32'h8000_0000);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
        checkOutput("t3_p31_tail", Pattern, 32'h7FFF_FFFF);
        idleCycles(10);

        // Burst timing: PERIOD=10, BURST=3 -> Done on cycle 31
        writeReg(BASE + 8'd1, 32'h0000_0085);
        writeReg(BASE + 8'd2, 32'd10);
        writeReg(BASE, {16'd3, 16'h0001});
        idleCycles(30);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
        checkOutput("t4_done", {31'd0, Done}, 32'd1);
        readExpect("t4_status", BASE + 8'd3, 32'h0000_0003);
        idleCycles(2);

        // Continuous run, START while busy ignored, STOP on a fire edge
        writeReg(BASE + 8'd1, 32'h0000_009E);
        writeReg(BASE + 8'd2, 32'd5);
        writeReg(BASE, 32'h0000_0001);
        idleCycles(2);
        writeReg(BASE, 32'h0000_0001);
        idleCycles(2);
        writeReg(BASE, 32'h0000_0002);
        checkOutput("t5_fire", Pattern, 32'hC000_0000);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
        checkOutput("t5_tail", Pattern, 32'h0000_0003);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
        checkOutput("t5_done", {31'd0, Done}, 32'd1);
        readCheck("t5_status", BASE + 8'd3);
        idleCycles(2);

        // Same-cycle START+STOP from idle: exactly one pulse
        writeReg(BASE, 32'h0000_0003);
        idleCycles(8);
        readCheck("t6_status", BASE + 8'd3);

        // Reset mid-pulse drops the tail word
        writeReg(BASE + 8'd2, 32'd20);
        writeReg(BASE, 32'h0000_0001);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0);
        checkOutput("t7_pattern", Pattern, 32'd0);
        readExpect("t7_period", BASE + 8'd2, 32'd100);
        readExpect("t7_miss", BASE + 8'd7, 32'd0);
        idleCycles(2);

        // Randomized bus traffic
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 399) == 0) begin
                applyStimulus(1'b0, 1'b0, 8'h00, 32'd0);
            end else if (r < 25) begin
                a = BASE + 8'($urandom_range(0, 4));
                case (a - BASE)
                    8'd0: d = {16'($urandom_range(0, 4)), 14'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
                    8'd2: d = {16'($urandom), 16'($urandom_range(0, 12))};
                    default: d = $urandom;
                endcase
                writeReg(a, d);
            end else begin
                applyStimulus(1'b1, 1'b0, 8'h00, 32'd0);
            end
            if ($urandom_range(0, 3) == 0) begin
                readCheck("rand_read", BASE + 8'($urandom_range(0, 5)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
